// File: rtl/vga_stream_sink_pkg.sv
// vga_stream_sink_pkg: shared types and default VGA 640x480 timing for the stream sink
package vga_stream_sink_pkg;

    localparam int H_SIZE = 10;
    localparam int V_SIZE = 10;

    localparam int VGA_H_DISPLAY = 640;
    localparam int VGA_H_FRONT   = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BACK    = 48;
    localparam int VGA_V_DISPLAY = 480;
    localparam int VGA_V_FRONT   = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BACK    = 33;

    // Only the frame marker travels with the sink's stream; it tags the first pixel of a frame.
    typedef struct packed {
        logic frame_start;
    } vga_fc_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_RUN
    } sink_state_t;

endpackage

// File: rtl/vga_stream_sink_fifo.sv
// vga_sync_fifo: single-clock FIFO with occupancy count and synchronous flush
module vga_sync_fifo #(
    parameter int WIDTH = 13,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q;
    logic [AW-1:0]    rd_q;
    logic [AW:0]      cnt_q;
    logic             do_push;
    logic             do_pop;

    assign full    = cnt_q == (AW+1)'(DEPTH);
    assign empty   = cnt_q == '0;
    assign count   = cnt_q;
    assign rdata   = mem_q[rd_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // pointers and occupancy; flush wins over any same-cycle push or pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (flush) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_q + AW'(do_push);
            rd_q  <= rd_q + AW'(do_pop);
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // storage needs no reset; occupancy decides what is valid
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= wdata;
    end

endmodule

// File: rtl/vga_stream_sink.sv
// vga_stream_sink: buffers the pixel stream and replays it against a free-running VGA raster
module vga_stream_sink
    import vga_stream_sink_pkg::*;
#(
    parameter int RGB_SIZE   = 12,
    parameter int FIFO_DEPTH = 16,
    parameter int H_DISPLAY  = VGA_H_DISPLAY,
    parameter int H_FRONT    = VGA_H_FRONT,
    parameter int H_SYNC     = VGA_H_SYNC,
    parameter int H_BACK     = VGA_H_BACK,
    parameter int V_DISPLAY  = VGA_V_DISPLAY,
    parameter int V_FRONT    = VGA_V_FRONT,
    parameter int V_SYNC     = VGA_V_SYNC,
    parameter int V_BACK     = VGA_V_BACK
) (
    input  logic                clk,
    input  logic                rst_n,
    input  vga_fc_t             src_fc,
    input  logic [RGB_SIZE-1:0] src_rgb,
    input  logic                src_vld,
    output logic                src_rdy,
    output logic                vga_hsync,
    output logic                vga_vsync,
    output logic [RGB_SIZE-1:0] vga_rgb,
    output logic                locked,
    output logic                err_underflow,
    output logic                err_misalign,
    input  logic                err_clr
);
    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int CW      = $clog2(FIFO_DEPTH) + 1;

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_DISPLAY);
    localparam logic [VW-1:0] V_ACT    = VW'(V_DISPLAY);
    localparam logic [HW-1:0] HS_FIRST = HW'(H_DISPLAY + H_FRONT);
    localparam logic [HW-1:0] HS_LAST  = HW'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [VW-1:0] VS_FIRST = VW'(V_DISPLAY + V_FRONT);
    localparam logic [VW-1:0] VS_LAST  = VW'(V_DISPLAY + V_FRONT + V_SYNC - 1);
    localparam logic [CW-1:0] HALF     = CW'(FIFO_DEPTH / 2);

    logic [HW-1:0]       hcnt_q;
    logic [VW-1:0]       vcnt_q;
    sink_state_t         state_q, state_d;
    logic                hsync_q, vsync_q;
    logic [RGB_SIZE-1:0] rgb_q;
    logic                err_u_q, err_m_q;

    logic                h_end, frame_end, origin, display;
    logic                push, pop, underflow, misalign;
    logic                full, empty;
    logic [CW-1:0]       count;
    logic                head_fs;
    logic [RGB_SIZE-1:0] head_rgb;

    assign h_end     = hcnt_q == H_LAST;
    assign frame_end = h_end && (vcnt_q == V_LAST);
    assign origin    = (hcnt_q == '0) && (vcnt_q == '0);
    assign display   = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);

    vga_sync_fifo #(
        .WIDTH (RGB_SIZE + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (underflow | misalign),
        .push  (push),
        .pop   (pop),
        .wdata ({src_fc.frame_start, src_rgb}),
        .rdata ({head_fs, head_rgb}),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    // free-running raster position; never stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
        end else begin
            hcnt_q <= h_end ? '0 : hcnt_q + HW'(1);
            if (h_end) vcnt_q <= (vcnt_q == V_LAST) ? '0 : vcnt_q + VW'(1);
        end
    end

    // lock state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // handshake, buffer control, error detection and next state
    always_comb begin
        state_d   = state_q;
        src_rdy   = 1'b1;
        push      = 1'b0;
        pop       = 1'b0;
        underflow = 1'b0;
        misalign  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                push = src_vld & src_fc.frame_start;
                if (push) state_d = ST_FILL;
            end
            ST_FILL: begin
                src_rdy = ~full;
                push    = src_vld & ~full;
                if (count >= HALF && frame_end) state_d = ST_RUN;
            end
            ST_RUN: begin
                underflow = display & empty;
                misalign  = display & ~empty & (head_fs != origin);
                src_rdy   = ~full & ~underflow & ~misalign;
                push      = src_vld & src_rdy;
                pop       = display & ~empty & ~misalign;
                if (underflow | misalign) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // registered video outputs and sticky errors; a same-cycle error beats err_clr
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            rgb_q   <= '0;
            err_u_q <= 1'b0;
            err_m_q <= 1'b0;
        end else begin
            hsync_q <= !((hcnt_q >= HS_FIRST) && (hcnt_q <= HS_LAST));
            vsync_q <= !((vcnt_q >= VS_FIRST) && (vcnt_q <= VS_LAST));
            rgb_q   <= pop ? head_rgb : '0;
            err_u_q <= underflow | (err_u_q & ~err_clr);
            err_m_q <= misalign | (err_m_q & ~err_clr);
        end
    end

    assign vga_hsync     = hsync_q;
    assign vga_vsync     = vsync_q;
    assign vga_rgb       = rgb_q;
    assign locked        = state_q == ST_RUN;
    assign err_underflow = err_u_q;
    assign err_misalign  = err_m_q;

endmodule
